// File: rtl/cart_pkg.sv
// cart_pkg: shared types, hotspot windows and helpers for the cartridge mapper
package cart_pkg;
  typedef enum logic [1:0] {MAP_4K, MAP_F8, MAP_F6, MAP_F4} mapper_t;
  typedef enum logic [1:0] {SRC_FF, SRC_ROM, SRC_RAM} src_t;
  localparam logic [12:0] F8_BASE = 13'h1FF8;
  localparam logic [12:0] F8_LIM = 13'h1FF9;
  localparam logic [12:0] F6_BASE = 13'h1FF6;
  localparam logic [12:0] F6_LIM = 13'h1FF9;
  localparam logic [12:0] F4_BASE = 13'h1FF4;
  localparam logic [12:0] F4_LIM = 13'h1FFB;
  localparam logic [12:0] SC_WR_BASE = 13'h1000;
  localparam logic [12:0] SC_RD_BASE = 13'h1080;
  function automatic logic [2:0] bank_mask(mapper_t m);
    return m == MAP_F4 ? 3'd7 : m == MAP_F6 ? 3'd3 : m == MAP_F8 ? 3'd1 : 3'd0;
  endfunction
  function automatic logic [12:0] hot_base(mapper_t m);
    return m == MAP_F4 ? F4_BASE : m == MAP_F6 ? F6_BASE : F8_BASE;
  endfunction
  function automatic logic [12:0] hot_lim(mapper_t m);
    return m == MAP_F4 ? F4_LIM : m == MAP_F6 ? F6_LIM : F8_LIM;
  endfunction
  function automatic logic hot_hit(mapper_t m, logic [12:0] a);
    return m != MAP_4K && a >= hot_base(m) && a <= hot_lim(m);
  endfunction
  function automatic logic [2:0] hot_bank(mapper_t m, logic [12:0] a);
    logic [12:0] b;
    logic [3:0] t;
    b = hot_base(m);
    t = a[3:0] - b[3:0];
    return t[2:0];
  endfunction
endpackage

// File: rtl/superchip_ram.sv
// superchip_ram: 128x8 single-clock RAM, one write port, registered read-before-write port
module superchip_ram (
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] wa,
  input  logic [7:0] wd,
  input  logic [6:0] ra,
  output logic [7:0] rd_q
);
  logic [7:0] mem [128];
  // write and registered read share one edge; the read sees the pre-write contents
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd_q <= mem[ra];
  end
endmodule

// File: rtl/cart_mapper.sv
// cart_mapper: 2600 cartridge bank switching (4K/F8/F6/F4) with optional Superchip RAM
module cart_mapper
  import cart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ph0,
  input  logic [12:0] a,
  input  logic        r,
  input  logic [7:0]  d_i,
  input  logic [1:0]  mapper,
  input  logic        sc_en,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_q,
  output logic [7:0]  d_o,
  output logic [2:0]  bank
);
  mapper_t mapper_q;
  logic sc_en_q;
  logic [2:0] bank_q, bank_d;
  src_t src_q, src_d;
  logic [7:0] d_o_q, d_o_d;
  logic [7:0] ram_q;
  logic sc_wr_win, sc_rd_win, ram_we;
  // window decode, bank switch on the ph0 clk only, and output source pipeline
  always_comb begin
    sc_wr_win = sc_en_q && a[12:7] == SC_WR_BASE[12:7];
    sc_rd_win = sc_en_q && a[12:7] == SC_RD_BASE[12:7];
    ram_we = !rst && ph0 && !r && sc_wr_win;
    bank_d = (ph0 && hot_hit(mapper_q, a)) ? hot_bank(mapper_q, a) : bank_q;
    src_d = (sc_rd_win && r) ? SRC_RAM : (a[12] && r && !sc_wr_win) ? SRC_ROM : SRC_FF;
    d_o_d = src_q == SRC_RAM ? ram_q : src_q == SRC_ROM ? rom_q : 8'hFF;
  end
  // reset latches the configuration and starts in the vector bank
  always_ff @(posedge clk) begin
    if (rst) begin
      mapper_q <= mapper_t'(mapper);
      sc_en_q <= sc_en;
      bank_q <= bank_mask(mapper_t'(mapper));
      src_q <= SRC_FF;
      d_o_q <= 8'hFF;
    end else begin
      bank_q <= bank_d;
      src_q <= src_d;
      d_o_q <= d_o_d;
    end
  end
  superchip_ram u_ram (
    .clk (clk),
    .we  (ram_we),
    .wa  (a[6:0]),
    .wd  (d_i),
    .ra  (a[6:0]),
    .rd_q(ram_q)
  );
  assign rom_addr = {bank_q & bank_mask(mapper_q), a[11:0]};
  assign bank = bank_q;
  assign d_o = d_o_q;
endmodule

// File: tb/tb_cart_mapper.sv
// tb_cart_mapper: directed scoreboard bench for cart_mapper
module tb_cart_mapper;
  logic clk = 0;
  logic rst, ph0, r, sc_en;
  logic [12:0] a;
  logic [1:0] mapper;
  logic [7:0] d_i, rom_q, d_o;
  logic [14:0] rom_addr;
  logic [2:0] bank;
  int total = 0, bad = 0;
  logic [7:0] exp_q [$];
  logic [2:0] bank_m;
  logic [1:0] map_m;
  logic sc_m;
  logic [7:0] ram_m [128];

  cart_mapper dut (
    .clk(clk), .rst(rst), .ph0(ph0), .a(a), .r(r), .d_i(d_i), .mapper(mapper),
    .sc_en(sc_en), .rom_addr(rom_addr), .rom_q(rom_q), .d_o(d_o), .bank(bank)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(logic [14:0] x);
    return x[7:0] ^ {1'b0, x[14:8]} ^ 8'h3C;
  endfunction

  always @(posedge clk) rom_q <= rom_fn(rom_addr);

  function automatic logic [2:0] mask_m(logic [1:0] m);
    return m == 2'd3 ? 3'd7 : m == 2'd2 ? 3'd3 : m == 2'd1 ? 3'd1 : 3'd0;
  endfunction

  function automatic logic [7:0] exp_d(logic [12:0] ad, logic rw);
    if (sc_m && rw && ad[12:7] == 6'h21) return ram_m[ad[6:0]];
    if (sc_m && ad[12:7] == 6'h20) return 8'hFF;
    if (ad[12] && rw) return rom_fn({bank_m & mask_m(map_m), ad[11:0]});
    return 8'hFF;
  endfunction

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(logic [1:0] m, logic sc);
    mapper = m; sc_en = sc; rst = 1; ph0 = 0; r = 1; a = 13'h0000; d_i = 8'h00;
    tick;
    rst = 0;
    map_m = m; sc_m = sc; bank_m = mask_m(m);
    check("rst_bank", {13'd0, bank}, {13'd0, bank_m});
    check("rst_do", {8'd0, d_o}, 16'h00FF);
  endtask

  task automatic cyc(logic [12:0] ad, logic rw, logic [7:0] wd, int ph_len);
    logic hit;
    logic [3:0] base, t;
    a = ad; r = rw; d_i = wd; ph0 = 1;
    exp_q.push_back(exp_d(ad, rw));
    #1;
    check("rom_addr", {1'b0, rom_addr}, {1'b0, bank_m & mask_m(map_m), ad[11:0]});
    hit = 0; base = 4'd0;
    case (map_m)
      2'd1: begin hit = ad inside {[13'h1FF8:13'h1FF9]}; base = 4'd8; end
      2'd2: begin hit = ad inside {[13'h1FF6:13'h1FF9]}; base = 4'd6; end
      2'd3: begin hit = ad inside {[13'h1FF4:13'h1FFB]}; base = 4'd4; end
      default: hit = 0;
    endcase
    t = ad[3:0] - base;
    if (hit) bank_m = t[2:0];
    if (sc_m && !rw && ad[12:7] == 6'h20) ram_m[ad[6:0]] = wd;
    @(posedge clk); #1; ph0 = (ph_len > 1);
    @(posedge clk); #1; ph0 = (ph_len > 2);
    check("d_o", {8'd0, d_o}, {8'd0, exp_q.pop_front()});
    @(posedge clk); #1; ph0 = 0;
    check("bank", {13'd0, bank}, {13'd0, bank_m});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    do_reset(2'd2, 1'b0);
    cyc(13'h1FFC, 1, 8'h00, 1);
    do_reset(2'd1, 1'b0);
    cyc(13'h1FF8, 1, 8'h00, 3);
    cyc(13'h1000, 1, 8'h00, 1);
    check("f8_b0_addr", {1'b0, rom_addr}, 16'h0000);
    cyc(13'h1FF9, 0, 8'h77, 1);
    cyc(13'h1FF6, 1, 8'h00, 1);
    cyc(13'h1FFB, 0, 8'h11, 1);
    cyc(13'h1234, 1, 8'h00, 1);
    do_reset(2'd3, 1'b1);
    cyc(13'h1005, 0, 8'h5A, 1);
    cyc(13'h1085, 1, 8'h00, 1);
    cyc(13'h1005, 1, 8'h00, 1);
    cyc(13'h1085, 0, 8'h33, 1);
    cyc(13'h1085, 1, 8'h00, 1);
    cyc(13'h107F, 0, 8'hC3, 1);
    cyc(13'h10FF, 1, 8'h00, 1);
    cyc(13'h1FF5, 1, 8'h00, 1);
    cyc(13'h1ABC, 1, 8'h00, 1);
    cyc(13'h0280, 1, 8'h00, 1);
    cyc(13'h0030, 1, 8'h00, 1);
    do_reset(2'd3, 1'b0);
    cyc(13'h1005, 1, 8'h00, 1);
    do_reset(2'd0, 1'b0);
    cyc(13'h1FF8, 1, 8'h00, 1);
    cyc(13'h1FF4, 0, 8'h00, 1);
    do_reset(2'd2, 1'b0);
    mapper = 2'd1;
    cyc(13'h1FF6, 1, 8'h00, 1);
    cyc(13'h1FF9, 1, 8'h00, 1);
    a = 13'h1FF7; r = 1; ph0 = 1; rst = 1;
    tick;
    rst = 0; ph0 = 0;
    check("rst_mid_bank", {13'd0, bank}, {13'd0, mask_m(2'd1)});
    check("rst_mid_do", {8'd0, d_o}, 16'h00FF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
